// File: rtl/dot_relu_engine_pkg.sv
// dot_relu_engine_pkg: shared widths, FSM states and the ReLU/shift/saturate helper.
package dot_relu_engine_pkg;

   localparam int unsigned NUM_TAPS    = 8;
   localparam int unsigned NUM_SAMPLES = 16;
   localparam int unsigned TAP_W       = 4;
   localparam int unsigned SAMPLE_W    = 8;
   localparam int unsigned ACC_W       = 16;
   localparam int unsigned OUT_W       = 8;
   localparam int unsigned PROD_W      = SAMPLE_W + TAP_W + 1;

   typedef enum logic [1:0] {IDLE, MAC, FIN} state_e;

   // Negative accumulators clamp to zero before the shift; anything above 8 bits saturates.
   function automatic logic [OUT_W-1:0] relu_sat(input logic [ACC_W-1:0] acc, input int unsigned sh);
      logic [ACC_W-1:0] r;
      r = acc[ACC_W-1] ? '0 : acc;
      r = r >> sh;
      return (|r[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : r[OUT_W-1:0];
   endfunction

endpackage

// File: rtl/dot_relu_engine_mac_unit.sv
// mac_unit: 8u x 4s multiply feeding one of two 16-bit signed accumulators.
module mac_unit
   import dot_relu_engine_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic                sel,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [TAP_W-1:0]    tap,
   output logic [ACC_W-1:0]    acc0,
   output logic [ACC_W-1:0]    acc1
);

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  acc0_q, acc1_q;

   // Zero-extend the sample so the whole product is evaluated signed.
   always_comb begin
      prod = PROD_W'($signed({1'b0, sample})) * PROD_W'($signed(tap));
      sum  = (sel ? acc1_q : acc0_q) + ACC_W'(prod);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc0_q <= '0;
         acc1_q <= '0;
      end else if (clr) begin
         acc0_q <= '0;
         acc1_q <= '0;
      end else if (en) begin
         acc0_q <= sel ? acc0_q : sum;
         acc1_q <= sel ? sum : acc1_q;
      end
   end

   assign acc0 = acc0_q;
   assign acc1 = acc1_q;

endmodule

// File: rtl/dot_relu_engine.sv
// dot_relu_engine: snapshots weights/data on start, runs 16 time-shared MACs,
// then writes two ReLU/shifted/saturated bytes.
module dot_relu_engine
   import dot_relu_engine_pkg::*;
#(
   parameter int unsigned SHIFT = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [NUM_TAPS*TAP_W-1:0]         weights,
   input  logic [NUM_SAMPLES*SAMPLE_W-1:0]   data,
   output logic                              busy,
   output logic                              done,
   output logic [2*OUT_W-1:0]                result,
   output logic                              result_valid
);

   state_e                            state_q;
   logic [3:0]                        idx_q;
   logic [NUM_TAPS*TAP_W-1:0]         w_q;
   logic [NUM_SAMPLES*SAMPLE_W-1:0]   d_q;
   logic [2*OUT_W-1:0]                result_q;
   logic                              done_q;
   logic                              rv_q;
   logic                              accept;
   logic [TAP_W-1:0]                  tap;
   logic [SAMPLE_W-1:0]               sample;
   logic [ACC_W-1:0]                  acc0, acc1;

   always_comb begin
      accept = (state_q == IDLE) && start;
      tap    = w_q[{idx_q[2:0], 2'b00} +: TAP_W];
      sample = d_q[{idx_q, 3'b000} +: SAMPLE_W];
   end

   mac_unit u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (state_q == MAC),
      .sel    (idx_q[3]),
      .sample (sample),
      .tap    (tap),
      .acc0   (acc0),
      .acc1   (acc1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         w_q      <= '0;
         d_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         rv_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               w_q     <= weights;
               d_q     <= data;
               idx_q   <= '0;
               rv_q    <= 1'b0;
               state_q <= MAC;
            end
            MAC: begin
               idx_q   <= idx_q + 4'd1;
               state_q <= (idx_q == 4'd15) ? FIN : MAC;
            end
            FIN: begin
               result_q <= {relu_sat(acc1, SHIFT), relu_sat(acc0, SHIFT)};
               done_q   <= 1'b1;
               rv_q     <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign result       = result_q;
   assign result_valid = rv_q;

endmodule
